// File: rtl/alu_pkg.sv
// Shared types for the ALU result path between execute and writeback.
package alu_pkg;

    localparam int WIDTH  = 32;
    localparam int RIDX_W = 5;

    typedef struct packed {
        logic [WIDTH-1:0]  res;
        logic [RIDX_W-1:0] rd;
        logic              wen;
        logic              zero;
        logic              neg;
    } alu_res_t;

endpackage

// File: rtl/result_fifo2.sv
// Two-entry valid/ready FIFO of ALU results with synchronous flush.
module result_fifo2
    import alu_pkg::*;
(
    input  logic     clk,
    input  logic     rst_n,
    input  logic     flush,
    input  logic     in_valid,
    output logic     in_ready,
    input  alu_res_t in_data,
    output logic     out_valid,
    input  logic     out_ready,
    output alu_res_t out_data
);

    logic [1:0] count_q, count_d;
    logic       rptr_q, rptr_d;
    logic       wptr_q, wptr_d;
    alu_res_t   mem_q [2];
    alu_res_t   mem_d [2];
    logic       push, pop;

    // Ready comes from registered count only, so no path from out_ready.
    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_data  = mem_q[rptr_q];
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_comb begin
        count_d = count_q;
        rptr_d  = rptr_q;
        wptr_d  = wptr_q;
        mem_d   = mem_q;
        if (flush) begin
            count_d = 2'd0;
            rptr_d  = 1'b0;
            wptr_d  = 1'b0;
        end else begin
            if (push) begin
                mem_d[wptr_q] = in_data;
                wptr_d        = ~wptr_q;
            end
            if (pop) begin
                rptr_d = ~rptr_q;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 2'd0;
            rptr_q  <= 1'b0;
            wptr_q  <= 1'b0;
            mem_q   <= '{default: '0};
        end else begin
            count_q <= count_d;
            rptr_q  <= rptr_d;
            wptr_q  <= wptr_d;
            mem_q   <= mem_d;
        end
    end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result pipeline stage: flag/wen capture, 2-deep buffer, retire counter.
module alu_result_stage #(
    parameter int WIDTH  = alu_pkg::WIDTH,
    parameter int RIDX_W = alu_pkg::RIDX_W,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_res,
    input  logic [RIDX_W-1:0] in_rd,
    input  logic              in_wen,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_res,
    output logic [RIDX_W-1:0] out_rd,
    output logic              out_wen,
    output logic              out_zero,
    output logic              out_neg,
    output logic [CNT_W-1:0]  retire_cnt
);
    import alu_pkg::*;

    alu_res_t         in_ent, head;
    logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;

    // x0 is hardwired, so its write enable is dropped at capture.
    always_comb begin
        in_ent      = '0;
        in_ent.res  = in_res;
        in_ent.rd   = in_rd;
        in_ent.wen  = in_wen & (in_rd != '0);
        in_ent.zero = (in_res == '0);
        in_ent.neg  = in_res[WIDTH-1];
    end

    result_fifo2 u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_ent),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (head)
    );

    assign out_res  = head.res;
    assign out_rd   = head.rd;
    assign out_wen  = head.wen;
    assign out_zero = head.zero;
    assign out_neg  = head.neg;

    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (out_valid && out_ready) begin
            retire_cnt_d = retire_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_cnt_q <= '0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed-vector bench for alu_result_stage.
module tb_alu_result_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_res = '0;
    logic [4:0]  in_rd = '0;
    logic        in_wen = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_res;
    logic [4:0]  out_rd;
    logic        out_wen;
    logic        out_zero;
    logic        out_neg;
    logic [31:0] retire_cnt;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    alu_result_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_res     (in_res),
        .in_rd      (in_rd),
        .in_wen     (in_wen),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_res    (out_res),
        .out_rd     (out_rd),
        .out_wen    (out_wen),
        .out_zero   (out_zero),
        .out_neg    (out_neg),
        .retire_cnt (retire_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] r,
                         input logic [4:0] d, input logic w);
        in_valid = v;
        in_res   = r;
        in_rd    = d;
        in_wen   = w;
    endtask

    initial begin
        #12;
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 1);
        chk("rst_cnt", retire_cnt, 0);
        chk("rst_res", out_res, 0);
        chk("rst_flags", {out_zero, out_neg, out_wen}, 0);
        rst_n = 1'b1;
        step();

        // single push of zero
        out_ready = 1'b1;
        drive(1, 32'h0, 5'd3, 1);
        step();
        drive(0, 0, 0, 0);
        chk("t1_valid", out_valid, 1);
        chk("t1_zero", out_zero, 1);
        chk("t1_neg", out_neg, 0);
        chk("t1_wen", out_wen, 1);
        chk("t1_rd", out_rd, 3);
        step();
        chk("t1_empty", out_valid, 0);
        chk("t1_cnt", retire_cnt, 1);

        // backpressure
        out_ready = 1'b0;
        drive(1, 32'h8000_0001, 5'd1, 1);
        step();
        drive(1, 32'h0000_0005, 5'd2, 1);
        step();
        chk("t2_full", in_ready, 0);
        chk("t2_head", out_res, 32'h8000_0001);
        chk("t2_neg", out_neg, 1);
        drive(1, 32'h9, 5'd4, 1);
        step();
        chk("t2_hold_rdy", in_ready, 0);
        chk("t2_hold_res", out_res, 32'h8000_0001);
        out_ready = 1'b1;
        step();
        chk("t2_rdy_back", in_ready, 1);
        chk("t2_second", out_res, 32'h5);
        step();
        drive(0, 0, 0, 0);
        chk("t2_third", out_res, 32'h9);
        chk("t2_third_rd", out_rd, 4);
        step();
        chk("t2_drain", out_valid, 0);
        chk("t2_cnt", retire_cnt, 4);

        // streaming push+pop every cycle
        for (int i = 0; i < 10; i++) begin
            drive(1, 32'd100 + 32'(i), 5'd7, 1);
            if (i > 0) begin
                chk("t3_ready", in_ready, 1);
                chk("t3_order", out_res, 32'd99 + 32'(i));
            end
            step();
        end
        drive(0, 0, 0, 0);
        chk("t3_last", out_res, 32'd109);
        step();
        chk("t3_empty", out_valid, 0);
        chk("t3_cnt", retire_cnt, 14);

        // write to x0
        drive(1, 32'd7, 5'd0, 1);
        step();
        drive(0, 0, 0, 0);
        chk("t4_wen", out_wen, 0);
        chk("t4_res", out_res, 7);
        chk("t4_zero", out_zero, 0);
        step();
        chk("t4_cnt", retire_cnt, 15);

        // flush with full buffer, pop and push in the same cycle
        out_ready = 1'b0;
        drive(1, 32'hA, 5'd1, 1);
        step();
        drive(1, 32'hB, 5'd1, 1);
        step();
        chk("t5_full", in_ready, 0);
        flush = 1'b1;
        out_ready = 1'b1;
        drive(1, 32'hC, 5'd1, 1);
        step();
        flush = 1'b0;
        out_ready = 1'b0;
        chk("t5_valid", out_valid, 0);
        chk("t5_cnt", retire_cnt, 16);
        chk("t5_ready", in_ready, 1);
        drive(1, 32'hD, 5'd9, 1);
        step();
        drive(0, 0, 0, 0);
        chk("t5_next", out_res, 32'hD);
        step();
        chk("t5_hold", out_res, 32'hD);

        // async reset with two entries held
        drive(1, 32'hE, 5'd2, 1);
        step();
        drive(0, 0, 0, 0);
        chk("t6_full", in_ready, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_valid", out_valid, 0);
        chk("t6_ready", in_ready, 1);
        chk("t6_cnt", retire_cnt, 0);
        chk("t6_res", out_res, 0);
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        drive(1, 32'hF, 5'd5, 1);
        step();
        drive(0, 0, 0, 0);
        chk("t6_after", out_res, 32'hF);
        chk("t6_after_v", out_valid, 1);
        step();
        chk("t6_after_cnt", retire_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
